// File: rtl/cache_pkg.sv
// Shared cache encodings: snoop request/response codes, MESI line states,
// snoop controller FSM states and the MESI snoop transition function.
package cache_pkg;

  localparam logic [1:0] SUREQ_RD   = 2'd0;
  localparam logic [1:0] SUREQ_INV  = 2'd1;
  localparam logic [1:0] SUREQ_RFO  = 2'd2;
  localparam logic [1:0] SUREQ_RSV  = 2'd3;

  localparam logic [1:0] SDRSP_OKAY = 2'd0;
  localparam logic [1:0] SDRSP_INV  = 2'd1;

  localparam logic [2:0] INVALID    = 3'd0;
  localparam logic [2:0] SHARED     = 3'd1;
  localparam logic [2:0] EXCLUSIVE  = 3'd2;
  localparam logic [2:0] MODIFIED   = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVAL,
    ST_WB,
    ST_UPDATE,
    ST_RSP
  } snp_st_e;

  // State a line moves to when it is snooped with the given op.
  // A reserved op leaves the line untouched.
  function automatic logic [2:0] mesi_snp_nxt_st(input logic [2:0] cur,
                                                 input logic [1:0] op);
    logic [2:0] nxt;
    case (op)
      SUREQ_RD:             nxt = SHARED;
      SUREQ_INV, SUREQ_RFO: nxt = INVALID;
      default:              nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/snp_req_fifo.sv
// Small synchronous FIFO holding queued snoop requests. DEPTH must be a
// power of two so the pointers wrap on their own.
module snp_req_fifo #(
  parameter  int DW    = 34,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];

  // Pointer and occupancy tracking; simultaneous push/pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are meaningless until counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/snp_req_ctrl_q.sv
// Queued snoop controller: takes one snoop at a time from the request FIFO,
// looks up the tag/state array, writes back dirty data, updates the MESI
// state and returns a snoop response.
module snp_req_ctrl_q
  import cache_pkg::*;
#(
  parameter  int ADDR_W   = 32,
  parameter  int NUM_WAYS = 4,
  parameter  int Q_DEPTH  = 4,
  parameter  int CNT_W    = 16,
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snp_req_vld,
  output logic              snp_req_rdy,
  input  logic [1:0]        snp_req_op,
  input  logic [ADDR_W-1:0] snp_req_addr,
  output logic              lkup_vld,
  output logic [ADDR_W-1:0] lkup_addr,
  input  logic              lkup_hit,
  input  logic [WAY_W-1:0]  lkup_way,
  input  logic [2:0]        lkup_st,
  output logic              upd_vld,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [WAY_W-1:0]  upd_way,
  output logic [2:0]        upd_st,
  output logic              wb_vld,
  input  logic              wb_rdy,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              snp_rsp_vld,
  input  logic              snp_rsp_rdy,
  output logic [1:0]        snp_rsp,
  output logic [ADDR_W-1:0] snp_rsp_addr,
  output logic              snp_rsp_wb,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int DW  = ADDR_W + 2;
  localparam int QAW = $clog2(Q_DEPTH);

  snp_st_e           r_state;
  snp_st_e           w_state_nxt;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [WAY_W-1:0]  r_way;
  logic [2:0]        r_cur;
  logic [2:0]        r_nxt;
  logic [1:0]        r_rsp;
  logic              r_dirty;
  logic [CNT_W-1:0]  r_hit_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DW-1:0]     w_head;
  logic [QAW:0]      w_count;
  logic [2:0]        w_cur;
  logic [2:0]        w_nxt;
  logic              w_rd_rfo;
  logic              w_dirty;
  logic [1:0]        w_rsp;

  // Holding rdy low during reset keeps requests from slipping in while the
  // queue is being cleared.
  assign snp_req_rdy = !rst && !w_full;
  assign w_push      = snp_req_vld && snp_req_rdy;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;

  snp_req_fifo #(
    .DW    (DW),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({snp_req_op, snp_req_addr}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Lookup evaluation, meaningful only in EVAL when the array answer is valid.
  assign w_cur    = lkup_hit ? lkup_st : INVALID;
  assign w_nxt    = mesi_snp_nxt_st(w_cur, r_op);
  assign w_rd_rfo = (r_op == SUREQ_RD) || (r_op == SUREQ_RFO);
  assign w_dirty  = (w_cur == MODIFIED) && w_rd_rfo;
  assign w_rsp    = ((w_cur != INVALID) && w_rd_rfo) ? SDRSP_OKAY : SDRSP_INV;

  assign busy    = (w_count != '0) || (r_state != ST_IDLE);
  assign hit_cnt = r_hit_cnt;

  // FSM state and saturating hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_EVAL) && lkup_hit && w_rd_rfo && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end
  end

  // Working registers: request fields on pop, lookup outcome in EVAL.
  always_ff @(posedge clk) begin
    if (w_pop) {r_op, r_addr} <= w_head;
    if (r_state == ST_EVAL) begin
      r_way   <= lkup_way;
      r_cur   <= w_cur;
      r_nxt   <= w_nxt;
      r_rsp   <= w_rsp;
      r_dirty <= w_dirty;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!w_empty) w_state_nxt = ST_LOOKUP;
      ST_LOOKUP: w_state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (w_dirty)                          w_state_nxt = ST_WB;
        else if (lkup_hit && (w_nxt != w_cur)) w_state_nxt = ST_UPDATE;
        else                                  w_state_nxt = ST_RSP;
      end
      ST_WB:     if (wb_rdy) w_state_nxt = (r_nxt != r_cur) ? ST_UPDATE : ST_RSP;
      ST_UPDATE: w_state_nxt = ST_RSP;
      ST_RSP:    if (snp_rsp_rdy) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; every output field is zero outside its own state.
  always_comb begin
    lkup_vld     = 1'b0;
    lkup_addr    = '0;
    upd_vld      = 1'b0;
    upd_addr     = '0;
    upd_way      = '0;
    upd_st       = '0;
    wb_vld       = 1'b0;
    wb_addr      = '0;
    snp_rsp_vld  = 1'b0;
    snp_rsp      = '0;
    snp_rsp_addr = '0;
    snp_rsp_wb   = 1'b0;
    case (r_state)
      ST_LOOKUP: begin
        lkup_vld  = 1'b1;
        lkup_addr = r_addr;
      end
      ST_WB: begin
        wb_vld  = 1'b1;
        wb_addr = r_addr;
      end
      ST_UPDATE: begin
        upd_vld  = 1'b1;
        upd_addr = r_addr;
        upd_way  = r_way;
        upd_st   = r_nxt;
      end
      ST_RSP: begin
        snp_rsp_vld  = 1'b1;
        snp_rsp      = r_rsp;
        snp_rsp_addr = r_addr;
        snp_rsp_wb   = r_dirty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snp_req_ctrl_q.sv
`timescale 1ns/1ps
module tb_snp_req_ctrl_q;
  import cache_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int NUM_WAYS = 4;
  localparam int Q_DEPTH  = 4;
  localparam int CNT_W    = 16;
  localparam int WAY_W    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              snp_req_vld = 1'b0;
  logic              snp_req_rdy;
  logic [1:0]        snp_req_op = 2'd0;
  logic [ADDR_W-1:0] snp_req_addr = '0;
  logic              lkup_vld;
  logic [ADDR_W-1:0] lkup_addr;
  logic              lkup_hit = 1'b0;
  logic [WAY_W-1:0]  lkup_way = '0;
  logic [2:0]        lkup_st = 3'd0;
  logic              upd_vld;
  logic [ADDR_W-1:0] upd_addr;
  logic [WAY_W-1:0]  upd_way;
  logic [2:0]        upd_st;
  logic              wb_vld;
  logic              wb_rdy = 1'b1;
  logic [ADDR_W-1:0] wb_addr;
  logic              snp_rsp_vld;
  logic              snp_rsp_rdy = 1'b1;
  logic [1:0]        snp_rsp;
  logic [ADDR_W-1:0] snp_rsp_addr;
  logic              snp_rsp_wb;
  logic              busy;
  logic [CNT_W-1:0]  hit_cnt;

  snp_req_ctrl_q #(
    .ADDR_W   (ADDR_W),
    .NUM_WAYS (NUM_WAYS),
    .Q_DEPTH  (Q_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .snp_req_vld  (snp_req_vld),
    .snp_req_rdy  (snp_req_rdy),
    .snp_req_op   (snp_req_op),
    .snp_req_addr (snp_req_addr),
    .lkup_vld     (lkup_vld),
    .lkup_addr    (lkup_addr),
    .lkup_hit     (lkup_hit),
    .lkup_way     (lkup_way),
    .lkup_st      (lkup_st),
    .upd_vld      (upd_vld),
    .upd_addr     (upd_addr),
    .upd_way      (upd_way),
    .upd_st       (upd_st),
    .wb_vld       (wb_vld),
    .wb_rdy       (wb_rdy),
    .wb_addr      (wb_addr),
    .snp_rsp_vld  (snp_rsp_vld),
    .snp_rsp_rdy  (snp_rsp_rdy),
    .snp_rsp      (snp_rsp),
    .snp_rsp_addr (snp_rsp_addr),
    .snp_rsp_wb   (snp_rsp_wb),
    .busy         (busy),
    .hit_cnt      (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        rsp;
    logic [ADDR_W-1:0] addr;
    logic              wb;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Tag array answer presented for the next lookup, and writeback stall length.
  logic             tb_hit = 1'b0;
  logic [WAY_W-1:0] tb_way = '0;
  logic [2:0]       tb_st  = 3'd0;
  int               wb_stall = 0;

  // Monitor state (written only by the monitor).
  int                lkup_cnt = 0;
  int                upd_cnt  = 0;
  int                wb_cyc   = 0;
  int                wb_run   = 0;
  int                wb_bad   = 0;
  logic [ADDR_W-1:0] wb_first = '0;
  logic [ADDR_W-1:0] upd_addr_s = '0;
  logic [WAY_W-1:0]  upd_way_s = '0;
  logic [2:0]        upd_st_s = 3'd0;

  // Tag array model, writeback sink and strobe monitor.
  always @(negedge clk) begin
    if (lkup_vld) begin
      lkup_hit <= tb_hit;
      lkup_way <= tb_way;
      lkup_st  <= tb_st;
      lkup_cnt <= lkup_cnt + 1;
    end
    if (upd_vld) begin
      upd_cnt    <= upd_cnt + 1;
      upd_addr_s <= upd_addr;
      upd_way_s  <= upd_way;
      upd_st_s   <= upd_st;
    end
    if (wb_vld) begin
      wb_cyc <= wb_cyc + 1;
      wb_run <= wb_run + 1;
      wb_rdy <= (wb_run + 1 > wb_stall);
      if (wb_run == 0) wb_first <= wb_addr;
      else if (wb_addr != wb_first) wb_bad <= wb_bad + 1;
    end else begin
      wb_run <= 0;
      wb_rdy <= 1'b1;
    end
  end

  // Present one request and hold it through its accept edge.
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a, input exp_t e);
    snp_req_op   = op;
    snp_req_addr = a;
    snp_req_vld  = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    snp_req_vld = 1'b0;
  endtask

  // Wait (bounded) for a response handshake and return what was offered.
  task automatic collect_rsp(inout int lat, output logic ok, output logic [1:0] r,
                             output logic [ADDR_W-1:0] a, output logic w);
    while (!(snp_rsp_vld && snp_rsp_rdy) && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = snp_rsp_vld && snp_rsp_rdy;
    r  = snp_rsp;
    a  = snp_rsp_addr;
    w  = snp_rsp_wb;
    if (ok) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (snp_req_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy_low: got %0b want 0", snp_req_rdy);
    end
    n_tests++;
    if ({lkup_vld, upd_vld, wb_vld, snp_rsp_vld, snp_rsp_wb, busy} !== 6'd0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000000",
                         {lkup_vld, upd_vld, wb_vld, snp_rsp_vld, snp_rsp_wb, busy});
    end
    n_tests++;
    if (hit_cnt !== '0) begin
      n_fail++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (snp_req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy_release: got %0b want 1", snp_req_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_miss();
    int lat; logic ok; logic [1:0] r; logic [ADDR_W-1:0] a; logic w; exp_t e;
    int u0, w0;
    tb_hit = 1'b0; tb_way = '0; tb_st = INVALID; wb_stall = 0;
    u0 = upd_cnt; w0 = wb_cyc;
    issue(SUREQ_RD, 32'h1000, '{SDRSP_INV, 32'h1000, 1'b0});
    lat = 1;
    collect_rsp(lat, ok, r, a, w);
    e = sb.pop_front();
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL miss_rsp_seen: got 0 want 1"); end
    n_tests++;
    if (lat !== 4) begin n_fail++; $display("FAIL miss_latency: got %0d want 4", lat); end
    n_tests++;
    if ({r, a, w} !== e) begin
      n_fail++; $display("FAIL miss_rsp: got rsp=%0d addr=%h wb=%0b want rsp=%0d addr=%h wb=%0b",
                         r, a, w, e.rsp, e.addr, e.wb);
    end
    n_tests++;
    if ((upd_cnt - u0) !== 0 || (wb_cyc - w0) !== 0) begin
      n_fail++; $display("FAIL miss_no_upd_wb: got upd=%0d wb=%0d want 0 0", upd_cnt - u0, wb_cyc - w0);
    end
    n_tests++;
    if (hit_cnt !== 16'd0) begin n_fail++; $display("FAIL miss_hit_cnt: got %0d want 0", hit_cnt); end
  endtask

  task automatic test_excl_hit();
    int lat; logic ok; logic [1:0] r; logic [ADDR_W-1:0] a; logic w; exp_t e;
    int u0;
    tb_hit = 1'b1; tb_way = 2'd2; tb_st = EXCLUSIVE; wb_stall = 0;
    u0 = upd_cnt;
    issue(SUREQ_RD, 32'h2040, '{SDRSP_OKAY, 32'h2040, 1'b0});
    lat = 1;
    collect_rsp(lat, ok, r, a, w);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat !== 5) begin n_fail++; $display("FAIL excl_latency: got ok=%0b lat=%0d want 1 5", ok, lat); end
    n_tests++;
    if ({r, a, w} !== e) begin
      n_fail++; $display("FAIL excl_rsp: got rsp=%0d addr=%h wb=%0b want rsp=%0d addr=%h wb=%0b",
                         r, a, w, e.rsp, e.addr, e.wb);
    end
    n_tests++;
    if ((upd_cnt - u0) !== 1 || upd_addr_s !== 32'h2040 || upd_way_s !== 2'd2 || upd_st_s !== SHARED) begin
      n_fail++; $display("FAIL excl_upd: got n=%0d addr=%h way=%0d st=%0d want 1 2040 2 %0d",
                         upd_cnt - u0, upd_addr_s, upd_way_s, upd_st_s, SHARED);
    end
    n_tests++;
    if (hit_cnt !== 16'd1) begin n_fail++; $display("FAIL excl_hit_cnt: got %0d want 1", hit_cnt); end
  endtask

  task automatic test_dirty();
    int lat; logic ok; logic [1:0] r; logic [ADDR_W-1:0] a; logic w; exp_t e;
    int u0, w0, b0;
    // RFO to a modified line with a writeback stalled for three cycles.
    tb_hit = 1'b1; tb_way = 2'd1; tb_st = MODIFIED; wb_stall = 3;
    u0 = upd_cnt; w0 = wb_cyc; b0 = wb_bad;
    issue(SUREQ_RFO, 32'h3080, '{SDRSP_OKAY, 32'h3080, 1'b1});
    lat = 1;
    collect_rsp(lat, ok, r, a, w);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat !== 9) begin n_fail++; $display("FAIL rfo_latency: got ok=%0b lat=%0d want 1 9", ok, lat); end
    n_tests++;
    if ((wb_cyc - w0) !== 4 || (wb_bad - b0) !== 0 || wb_first !== 32'h3080) begin
      n_fail++; $display("FAIL rfo_wb_hold: got cyc=%0d unstable=%0d addr=%h want 4 0 3080",
                         wb_cyc - w0, wb_bad - b0, wb_first);
    end
    n_tests++;
    if ((upd_cnt - u0) !== 1 || upd_addr_s !== 32'h3080 || upd_way_s !== 2'd1 || upd_st_s !== INVALID) begin
      n_fail++; $display("FAIL rfo_upd: got n=%0d addr=%h way=%0d st=%0d want 1 3080 1 0",
                         upd_cnt - u0, upd_addr_s, upd_way_s, upd_st_s);
    end
    n_tests++;
    if ({r, a, w} !== e) begin
      n_fail++; $display("FAIL rfo_rsp: got rsp=%0d addr=%h wb=%0b want rsp=%0d addr=%h wb=%0b",
                         r, a, w, e.rsp, e.addr, e.wb);
    end
    // RD to a modified line, writeback accepted immediately.
    tb_hit = 1'b1; tb_way = 2'd3; tb_st = MODIFIED; wb_stall = 0;
    u0 = upd_cnt; w0 = wb_cyc;
    issue(SUREQ_RD, 32'h4000, '{SDRSP_OKAY, 32'h4000, 1'b1});
    lat = 1;
    collect_rsp(lat, ok, r, a, w);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat !== 6) begin n_fail++; $display("FAIL rd_dirty_latency: got ok=%0b lat=%0d want 1 6", ok, lat); end
    n_tests++;
    if ((wb_cyc - w0) !== 1 || (upd_cnt - u0) !== 1 || upd_st_s !== SHARED || upd_way_s !== 2'd3) begin
      n_fail++; $display("FAIL rd_dirty_wb_upd: got wb=%0d upd=%0d st=%0d way=%0d want 1 1 %0d 3",
                         wb_cyc - w0, upd_cnt - u0, upd_st_s, upd_way_s, SHARED);
    end
    n_tests++;
    if ({r, a, w} !== e) begin
      n_fail++; $display("FAIL rd_dirty_rsp: got rsp=%0d addr=%h wb=%0b want rsp=%0d addr=%h wb=%0b",
                         r, a, w, e.rsp, e.addr, e.wb);
    end
    n_tests++;
    if (hit_cnt !== 16'd3) begin n_fail++; $display("FAIL dirty_hit_cnt: got %0d want 3", hit_cnt); end
  endtask

  task automatic test_inv_rsv();
    int lat; logic ok; logic [1:0] r; logic [ADDR_W-1:0] a; logic w; exp_t e;
    int u0;
    tb_hit = 1'b1; tb_way = 2'd0; tb_st = SHARED; wb_stall = 0;
    u0 = upd_cnt;
    issue(SUREQ_INV, 32'h50C0, '{SDRSP_INV, 32'h50C0, 1'b0});
    lat = 1;
    collect_rsp(lat, ok, r, a, w);
    e = sb.pop_front();
    n_tests++;
    if (!ok || {r, a, w} !== e) begin
      n_fail++; $display("FAIL inv_rsp: got ok=%0b rsp=%0d addr=%h wb=%0b want rsp=%0d addr=%h wb=%0b",
                         ok, r, a, w, e.rsp, e.addr, e.wb);
    end
    n_tests++;
    if ((upd_cnt - u0) !== 1 || upd_st_s !== INVALID || upd_addr_s !== 32'h50C0) begin
      n_fail++; $display("FAIL inv_upd: got n=%0d st=%0d addr=%h want 1 0 50c0", upd_cnt - u0, upd_st_s, upd_addr_s);
    end
    tb_hit = 1'b1; tb_way = 2'd1; tb_st = EXCLUSIVE;
    u0 = upd_cnt;
    issue(SUREQ_RSV, 32'h6100, '{SDRSP_INV, 32'h6100, 1'b0});
    lat = 1;
    collect_rsp(lat, ok, r, a, w);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat !== 4 || {r, a, w} !== e) begin
      n_fail++; $display("FAIL rsv_rsp: got ok=%0b lat=%0d rsp=%0d addr=%h want lat=4 rsp=%0d addr=%h",
                         ok, lat, r, a, e.rsp, e.addr);
    end
    n_tests++;
    if ((upd_cnt - u0) !== 0 || hit_cnt !== 16'd3) begin
      n_fail++; $display("FAIL rsv_no_upd: got upd=%0d hit_cnt=%0d want 0 3", upd_cnt - u0, hit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic ok; logic [1:0] r; logic [ADDR_W-1:0] a; logic w; exp_t e;
    logic [ADDR_W-1:0] ad;
    logic seen_rsp;
    tb_hit = 1'b0; tb_st = INVALID; wb_stall = 0;
    snp_rsp_rdy = 1'b0;
    for (int i = 0; i < Q_DEPTH + 1; i++) begin
      ad = ADDR_W'(32'h8000 + i * 64);
      snp_req_op = SUREQ_RD; snp_req_addr = ad; snp_req_vld = 1'b1;
      n_tests++;
      if (snp_req_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy_%0d: got 0 want 1", i); end
      sb.push_back('{SDRSP_INV, ad, 1'b0});
      @(posedge clk); #1;
    end
    n_tests++;
    if (snp_req_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got rdy=1 want 0"); end
    // Offer one more while full; it must be dropped.
    snp_req_addr = 32'h8F00;
    repeat (3) begin @(posedge clk); #1; end
    n_tests++;
    if (snp_req_rdy !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_hold_full: got rdy=%0b busy=%0b want 0 1", snp_req_rdy, busy);
    end
    snp_req_vld = 1'b0;
    snp_rsp_rdy = 1'b1;
    for (int i = 0; i < Q_DEPTH + 1; i++) begin
      lat = 0;
      collect_rsp(lat, ok, r, a, w);
      e = sb.pop_front();
      n_tests++;
      if (!ok || {r, a, w} !== e) begin
        n_fail++; $display("FAIL b2b_order_%0d: got ok=%0b rsp=%0d addr=%h wb=%0b want rsp=%0d addr=%h wb=%0b",
                           i, ok, r, a, w, e.rsp, e.addr, e.wb);
      end
    end
    seen_rsp = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (snp_rsp_vld) seen_rsp = 1'b1;
    end
    n_tests++;
    if (seen_rsp !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_dropped_extra: got rsp=%0b busy=%0b want 0 0", seen_rsp, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int guard; int l0; logic seen_rsp;
    tb_hit = 1'b1; tb_way = 2'd1; tb_st = MODIFIED; wb_stall = 1000;
    issue(SUREQ_RFO, 32'h7000, '{SDRSP_OKAY, 32'h7000, 1'b1});
    issue(SUREQ_RD,  32'h7040, '{SDRSP_INV, 32'h7040, 1'b0});
    issue(SUREQ_RD,  32'h7080, '{SDRSP_INV, 32'h7080, 1'b0});
    guard = 0;
    while (!wb_vld && guard < 20) begin @(posedge clk); #1; guard++; end
    n_tests++;
    if (wb_vld !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_wb: got wb_vld=%0b busy=%0b want 1 1", wb_vld, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({snp_req_rdy, lkup_vld, upd_vld, wb_vld, snp_rsp_vld, snp_rsp_wb, busy} !== 7'd0) begin
      n_fail++; $display("FAIL rstmid_strobes: got %b want 0000000",
                         {snp_req_rdy, lkup_vld, upd_vld, wb_vld, snp_rsp_vld, snp_rsp_wb, busy});
    end
    n_tests++;
    if ((lkup_addr | upd_addr | wb_addr | snp_rsp_addr) !== '0 || {upd_way, upd_st, snp_rsp} !== '0) begin
      n_fail++; $display("FAIL rstmid_data: got addr_or=%h way/st/rsp=%b want 0",
                         lkup_addr | upd_addr | wb_addr | snp_rsp_addr, {upd_way, upd_st, snp_rsp});
    end
    n_tests++;
    if (hit_cnt !== '0) begin n_fail++; $display("FAIL rstmid_hit_cnt: got %0d want 0", hit_cnt); end
    rst = 1'b0;
    wb_stall = 0;
    sb.delete();
    #1;
    n_tests++;
    if (snp_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy: got 0 want 1"); end
    l0 = lkup_cnt;
    seen_rsp = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (snp_rsp_vld || busy) seen_rsp = 1'b1;
    end
    n_tests++;
    if (seen_rsp !== 1'b0 || (lkup_cnt - l0) !== 0) begin
      n_fail++; $display("FAIL rstmid_dropped: got activity=%0b lookups=%0d want 0 0", seen_rsp, lkup_cnt - l0);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_excl_hit();
    test_dirty();
    test_inv_rsv();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
